// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Buffered 8-bit UART transmitter. The host pushes bytes into a small FIFO.
//   The FSM pops them and serialises each one LSB-first as an 8N1 frame, or
//   as an 8O1 frame when UART_TX_PARITY_EN is defined. Every bit lasts
//   exactly BAUD_DIV clock cycles.
//
// Configuration macro
//   UART_TX_PARITY_EN  defined: an odd-parity bit follows data bit 7
//                      (11-bit frame). Undefined: 8N1 (10-bit frame).
//
// Ports
//   clk_i       system clock, rising edge
//   rst_i       synchronous reset, active high
//   wr_i        write strobe
//   wdata_i     byte to transmit
//   rdy_o       FIFO can accept a byte (combinational: ~full & ~rst_i)
//   tx_o        serial line, idle high, registered
//   busy_o      a frame is in progress or the FIFO is non-empty, registered
//   fifo_cnt_o  bytes held in the FIFO (the byte in the shifter is not counted)
//   dbg_state   current FSM state, for observation only
//
// Handshake: a byte is accepted on a rising edge where wr_i & rdy_o. When
// rdy_o is low, wr_i is ignored and the byte is lost. Because rdy_o is
// derived from the stored pointers, a write that arrives in the same cycle
// as a pop while the FIFO is full is also dropped.
module uart_tx_fifo #(
  parameter int BAUD_DIV   = 217,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        wr_i,
  input  logic [7:0]                  wdata_i,
  output logic                        rdy_o,
  output logic                        tx_o,
  output logic                        busy_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_cnt_o,
  output logic [2:0]                  dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t        state, state_next;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          full, empty, push, pop;
  logic          nonempty_q;
  logic          start_ok;
  logic [7:0]    head;
  logic [7:0]    shifter, shifter_next;
  logic [CW-1:0] baud_cnt, baud_next;
  logic [2:0]    bit_cnt, bit_next;
  logic          tx_next;
  logic          bit_done;
`ifdef UART_TX_PARITY_EN
  logic          parity_q, parity_next;
`endif

  // The pointers carry one extra wrap bit, so full and empty can be told apart.
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty      = (wr_ptr == rd_ptr);
  assign rdy_o      = ~full & ~rst_i;
  assign push       = wr_i & rdy_o;
  assign fifo_cnt_o = wr_ptr - rd_ptr;
  assign head       = mem[rd_ptr[AW-1:0]];
  assign dbg_state  = state;
  assign bit_done   = (baud_cnt == BAUD_LAST);

  // A new frame starts only from the registered non-empty flag. This adds
  // the extra cycle of write-to-start latency. The live empty term keeps a
  // stale flag from ever popping an empty FIFO.
  assign start_ok   = nonempty_q & ~empty;

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata_i;
  end

  always_comb begin
    state_next   = state;
    tx_next      = tx_o;
    shifter_next = shifter;
    baud_next    = baud_cnt;
    bit_next     = bit_cnt;
    pop          = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_next  = parity_q;
`endif
    case (state)
      S_IDLE: begin
        if (start_ok) begin
          pop          = 1'b1;
          shifter_next = head;
`ifdef UART_TX_PARITY_EN
          parity_next  = ~^head;
`endif
          tx_next      = 1'b0;
          baud_next    = '0;
          state_next   = S_START;
        end
      end
      S_START: begin
        if (bit_done) begin
          baud_next  = '0;
          bit_next   = '0;
          tx_next    = shifter[0];
          state_next = S_DATA;
        end else begin
          baud_next = baud_cnt + CW'(1);
        end
      end
      S_DATA: begin
        if (bit_done) begin
          baud_next = '0;
          if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            tx_next    = parity_q;
            state_next = S_PARITY;
`else
            tx_next    = 1'b1;
            state_next = S_STOP;
`endif
          end else begin
            // The line always shows shifter[0], so load the next bit now.
            shifter_next = shifter >> 1;
            tx_next      = shifter[1];
            bit_next     = bit_cnt + 3'd1;
          end
        end else begin
          baud_next = baud_cnt + CW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_done) begin
          baud_next  = '0;
          tx_next    = 1'b1;
          state_next = S_STOP;
        end else begin
          baud_next = baud_cnt + CW'(1);
        end
      end
`endif
      S_STOP: begin
        if (bit_done) begin
          baud_next = '0;
          if (start_ok) begin
            // Chain straight into the next start bit, with no idle gap.
            pop          = 1'b1;
            shifter_next = head;
`ifdef UART_TX_PARITY_EN
            parity_next  = ~^head;
`endif
            tx_next      = 1'b0;
            state_next   = S_START;
          end else begin
            tx_next    = 1'b1;
            state_next = S_IDLE;
          end
        end else begin
          baud_next = baud_cnt + CW'(1);
        end
      end
      default: begin
        tx_next    = 1'b1;
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      tx_o       <= 1'b1;
      busy_o     <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      nonempty_q <= 1'b0;
      shifter    <= '0;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state      <= state_next;
      tx_o       <= tx_next;
      shifter    <= shifter_next;
      baud_cnt   <= baud_next;
      bit_cnt    <= bit_next;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_next;
`endif
      nonempty_q <= ~empty;
      // busy drops one edge after the FSM has returned to IDLE with nothing queued.
      busy_o     <= (state != S_IDLE) || ~empty;
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
//   Directed bench for uart_tx_fifo with BAUD_DIV=4 and FIFO_DEPTH=4. A line
//   monitor decodes each frame by sampling at the bit centres. It records the
//   start cycle and the line bits of every frame. The test tasks compare what
//   the monitor saw against hand-computed frames and cycle numbers.
module tb_uart_tx_fifo;

  localparam int BD = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FR = NB * BD;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr;
  logic [7:0]  wdata;
  logic        rdy_o, tx_o, busy_o;
  logic [2:0]  fifo_cnt_o;
  logic [2:0]  dbg_state;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [10:0] exp_q[$];
  logic [10:0] rx_q[$];
  int          start_q[$];

  uart_tx_fifo #(.BAUD_DIV(BD), .FIFO_DEPTH(4)) dut (
    .clk_i(clk), .rst_i(rst), .wr_i(wr), .wdata_i(wdata),
    .rdy_o(rdy_o), .tx_o(tx_o), .busy_o(busy_o),
    .fifo_cnt_o(fifo_cnt_o), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Line monitor. Bit k of a frame is sampled at negedge offset 4k+2 from the start.
  initial begin : monitor
    bit          mon_active;
    int          mon_t;
    logic [10:0] mon_bits;
    mon_active = 1'b0;
    mon_t = 0;
    mon_bits = '0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        mon_active = 1'b0;
      end else if (!mon_active) begin
        if (tx_o === 1'b0) begin
          mon_active = 1'b1;
          mon_t = 0;
          mon_bits = '0;
          start_q.push_back(cyc);
        end
      end else begin
        mon_t++;
      end
      if (mon_active && (mon_t % BD) == 2) mon_bits[mon_t / BD] = tx_o;
      if (mon_active && mon_t == FR - 1) begin
        rx_q.push_back(mon_bits);
        mon_active = 1'b0;
      end
    end
  end

  // Expected line bits: start 0, data LSB first, optional odd parity, stop 1.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
    logic [10:0] f;
    f = '0;
    f[8:1] = b;
`ifdef UART_TX_PARITY_EN
    f[9]  = ~^b;
    f[10] = 1'b1;
`else
    f[9]  = 1'b1;
`endif
    return f;
  endfunction

  // driver tasks
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_queues;
    exp_q.delete();
    rx_q.delete();
    start_q.delete();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step();
    checks++;
    if (tx_o !== 1'b1 || busy_o !== 1'b0 || fifo_cnt_o !== 3'd0 || rdy_o !== 1'b0 || dbg_state !== 3'd0) begin
      errors++;
      $display("FAIL reset_hold: tx=%b busy=%b cnt=%0d rdy=%b st=%0d, want 1 0 0 0 0", tx_o, busy_o, fifo_cnt_o, rdy_o, dbg_state);
    end
    rst = 1'b0;
    #1;
    for (int i = 0; i < 100; i++) begin
      checks++;
      if (tx_o !== 1'b1 || busy_o !== 1'b0 || rdy_o !== 1'b1 || fifo_cnt_o !== 3'd0) begin
        errors++;
        $display("FAIL reset_idle@%0d: tx=%b busy=%b rdy=%b cnt=%0d, want 1 0 1 0", i, tx_o, busy_o, rdy_o, fifo_cnt_o);
      end
      step();
    end
  endtask

  task automatic test_single;
    int n;
    int k;
    logic [10:0] exp_f;
    logic [10:0] got;
    clear_queues();
`ifdef UART_TX_PARITY_EN
    exp_q.push_back(11'h74A);   // 0 1010_0101(LSB first) parity 1 stop 1
`else
    exp_q.push_back(11'h34A);   // line bits 0,1,0,1,0,0,1,0,1,1
`endif
    wr = 1'b1; wdata = 8'hA5;
    step();
    wr = 1'b0;
    n = cyc;
    checks++;
    if (fifo_cnt_o !== 3'd1 || tx_o !== 1'b1) begin
      errors++;
      $display("FAIL single_write: cnt=%0d tx=%b, want 1 1", fifo_cnt_o, tx_o);
    end
    step();
    checks++;
    if (tx_o !== 1'b1 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL single_n1: tx=%b busy=%b, want 1 1", tx_o, busy_o);
    end
    step();
    checks++;
    if (tx_o !== 1'b0 || fifo_cnt_o !== 3'd0) begin
      errors++;
      $display("FAIL single_latency: tx=%b cnt=%0d at write+2, want 0 0", tx_o, fifo_cnt_o);
    end
    k = 0;
    while (busy_o !== 1'b0 && k < 200) begin
      step();
      k++;
    end
    checks++;
    if (cyc !== n + 2 + FR + 1 || tx_o !== 1'b1) begin
      errors++;
      $display("FAIL single_busy_fall: cycle=%0d tx=%b, want cycle %0d tx 1", cyc, tx_o, n + 2 + FR + 1);
    end
    checks++;
    if (start_q.size() != 1 || rx_q.size() != 1) begin
      errors++;
      $display("FAIL single_frames: starts=%0d frames=%0d, want 1 1", start_q.size(), rx_q.size());
    end else begin
      exp_f = exp_q.pop_front();
      got = rx_q.pop_front();
      checks++;
      if (got !== exp_f) begin
        errors++;
        $display("FAIL single_bits: got %h want %h", got, exp_f);
      end
      checks++;
      if (start_q[0] !== n + 2) begin
        errors++;
        $display("FAIL single_start: got cycle %0d want %0d", start_q[0], n + 2);
      end
    end
  endtask

  task automatic test_back_to_back;
    int n;
    int k;
    logic [10:0] exp_f;
    logic [10:0] got;
    clear_queues();
    for (int i = 0; i < 3; i++) begin
      wr = 1'b1; wdata = 8'(i + 1);
      exp_q.push_back(frame_of(8'(i + 1)));
      step();
      if (i == 0) n = cyc;
    end
    wr = 1'b0;
    k = 0;
    while (busy_o !== 1'b0 && k < 400) begin
      step();
      k++;
    end
    checks++;
    if (cyc !== n + 2 + 3 * FR + 1) begin
      errors++;
      $display("FAIL b2b_busy_fall: cycle=%0d want %0d", cyc, n + 2 + 3 * FR + 1);
    end
    checks++;
    if (rx_q.size() != 3 || start_q.size() != 3) begin
      errors++;
      $display("FAIL b2b_count: frames=%0d starts=%0d want 3 3", rx_q.size(), start_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        exp_f = exp_q.pop_front();
        got = rx_q.pop_front();
        checks++;
        if (got !== exp_f || start_q[i] !== n + 2 + i * FR) begin
          errors++;
          $display("FAIL b2b_frame%0d: bits %h start %0d, want %h start %0d", i, got, start_q[i], exp_f, n + 2 + i * FR);
        end
      end
    end
  endtask

  task automatic test_overflow;
    int n;
    int k;
    logic [10:0] exp_f;
    logic [10:0] got;
    clear_queues();
    for (int i = 0; i < 5; i++) exp_q.push_back(frame_of(8'h10 + 8'(i)));
    for (int i = 0; i < 6; i++) begin
      wr = 1'b1; wdata = 8'h10 + 8'(i);
      step();
      if (i == 0) n = cyc;
      if (i == 4) begin
        checks++;
        if (rdy_o !== 1'b0 || fifo_cnt_o !== 3'd4) begin
          errors++;
          $display("FAIL ovf_full: rdy=%b cnt=%0d want 0 4", rdy_o, fifo_cnt_o);
        end
      end
      if (i == 5) begin
        checks++;
        if (fifo_cnt_o !== 3'd4) begin
          errors++;
          $display("FAIL ovf_drop: cnt=%0d want 4", fifo_cnt_o);
        end
      end
    end
    wr = 1'b0;
    k = 0;
    while (busy_o !== 1'b0 && k < 600) begin
      step();
      k++;
    end
    checks++;
    if (cyc !== n + 2 + 5 * FR + 1 || rdy_o !== 1'b1) begin
      errors++;
      $display("FAIL ovf_busy_fall: cycle=%0d rdy=%b want %0d 1", cyc, rdy_o, n + 2 + 5 * FR + 1);
    end
    repeat (2 * FR) step();
    checks++;
    if (rx_q.size() != 5) begin
      errors++;
      $display("FAIL ovf_count: frames=%0d want 5", rx_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        exp_f = exp_q.pop_front();
        got = rx_q.pop_front();
        checks++;
        if (got !== exp_f) begin
          errors++;
          $display("FAIL ovf_frame%0d: got %h want %h", i, got, exp_f);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    int lows;
    clear_queues();
    wr = 1'b1; wdata = 8'hFF; step();
    wdata = 8'hAA; step();
    wdata = 8'h55; step();
    wr = 1'b0;
    checks++;
    if (fifo_cnt_o !== 3'd2 || tx_o !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_queued: cnt=%0d tx=%b want 2 0", fifo_cnt_o, tx_o);
    end
    repeat (9) step();
    checks++;
    if (dbg_state !== 3'd2) begin
      errors++;
      $display("FAIL rstmid_in_data: state=%0d want 2", dbg_state);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++;
    if (tx_o !== 1'b1 || fifo_cnt_o !== 3'd0 || busy_o !== 1'b0 || rdy_o !== 1'b1 || dbg_state !== 3'd0) begin
      errors++;
      $display("FAIL rstmid_after: tx=%b cnt=%0d busy=%b rdy=%b st=%0d want 1 0 0 1 0", tx_o, fifo_cnt_o, busy_o, rdy_o, dbg_state);
    end
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (tx_o !== 1'b1 || busy_o !== 1'b0) lows++;
    end
    checks++;
    if (lows != 0 || rx_q.size() != 0 || start_q.size() != 1) begin
      errors++;
      $display("FAIL rstmid_quiet: active_cycles=%0d frames=%0d starts=%0d want 0 0 1", lows, rx_q.size(), start_q.size());
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity;
    int n;
    int k;
    logic [10:0] got;
    clear_queues();
    exp_q.push_back(11'h40E);   // 0, 1,1,1,0,0,0,0,0, parity 0, stop 1
    wr = 1'b1; wdata = 8'h07;
    step();
    wr = 1'b0;
    n = cyc;
    k = 0;
    while (busy_o !== 1'b0 && k < 200) begin
      step();
      k++;
    end
    checks++;
    if (cyc !== n + 2 + 44 + 1) begin
      errors++;
      $display("FAIL parity_span: busy fell at %0d want %0d", cyc, n + 2 + 44 + 1);
    end
    checks++;
    if (rx_q.size() != 1) begin
      errors++;
      $display("FAIL parity_count: frames=%0d want 1", rx_q.size());
    end else begin
      got = rx_q.pop_front();
      checks++;
      if (got !== exp_q[0]) begin
        errors++;
        $display("FAIL parity_bits: got %h want %h", got, exp_q[0]);
      end
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    wr = 1'b0;
    wdata = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
